// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter sharing one slave port.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that errors out a transfer the slave never answers.
module wb_rr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              CLK_I,
    input  logic              RST_NI,

    input  logic              M0_CYC_I,
    input  logic              M0_STB_I,
    input  logic              M0_WE_I,
    input  logic [ADDR_W-1:0] M0_ADR_I,
    input  logic [DATA_W-1:0] M0_DAT_I,
    output logic              M0_ACK_O,
    output logic              M0_ERR_O,
    output logic [DATA_W-1:0] M0_DAT_O,

    input  logic              M1_CYC_I,
    input  logic              M1_STB_I,
    input  logic              M1_WE_I,
    input  logic [ADDR_W-1:0] M1_ADR_I,
    input  logic [DATA_W-1:0] M1_DAT_I,
    output logic              M1_ACK_O,
    output logic              M1_ERR_O,
    output logic [DATA_W-1:0] M1_DAT_O,

    output logic              S_CYC_O,
    output logic              S_STB_O,
    output logic              S_WE_O,
    output logic [ADDR_W-1:0] S_ADR_O,
    output logic [DATA_W-1:0] S_DAT_O,
    input  logic              S_ACK_I,
    input  logic              S_ERR_I,
    input  logic [DATA_W-1:0] S_DAT_I,

    output logic [1:0]        GNT_O
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state, state_nxt;
    logic [1:0] gnt, gnt_nxt;
    logic       last, last_nxt;
    logic       timeout;
    logic       ack_fwd, err_fwd;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                // On contention the master not served last wins
                if (M0_CYC_I && (!M1_CYC_I || last)) state_nxt = GNT0;
                else if (M1_CYC_I)                   state_nxt = GNT1;
            end
            GNT0: begin
                if (!M0_CYC_I) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            GNT1: begin
                if (!M1_CYC_I) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        gnt_nxt = {state_nxt == GNT1, state_nxt == GNT0};
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       stb_raw;

    assign stb_raw = (gnt[0] & M0_STB_I) | (gnt[1] & M1_STB_I);
    assign timeout = (to_cnt == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI)
            to_cnt <= '0;
        else if (stb_raw && !S_ACK_I && !S_ERR_I && !timeout && (state_nxt == state))
            to_cnt <= to_cnt + 8'd1;
        else
            to_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        S_CYC_O = 1'b0;
        S_STB_O = 1'b0;
        S_WE_O  = 1'b0;
        S_ADR_O = '0;
        S_DAT_O = '0;
        if (gnt[0]) begin
            S_CYC_O = M0_CYC_I;
            S_STB_O = M0_STB_I & ~timeout;
            S_WE_O  = M0_WE_I;
            S_ADR_O = M0_ADR_I;
            S_DAT_O = M0_DAT_I;
        end else if (gnt[1]) begin
            S_CYC_O = M1_CYC_I;
            S_STB_O = M1_STB_I & ~timeout;
            S_WE_O  = M1_WE_I;
            S_ADR_O = M1_ADR_I;
            S_DAT_O = M1_DAT_I;
        end
    end

    // ERR dominates a simultaneous ACK, including a late ACK in the watchdog cycle
    assign ack_fwd = S_ACK_I & ~S_ERR_I & ~timeout;
    assign err_fwd = S_ERR_I | timeout;

    assign M0_ACK_O = gnt[0] & ack_fwd;
    assign M0_ERR_O = gnt[0] & err_fwd;
    assign M0_DAT_O = gnt[0] ? S_DAT_I : '0;
    assign M1_ACK_O = gnt[1] & ack_fwd;
    assign M1_ERR_O = gnt[1] & err_fwd;
    assign M1_DAT_O = gnt[1] ? S_DAT_I : '0;

    assign GNT_O = gnt;

endmodule
